pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 98 +++++++++
 tb/tb_pc_stack_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with a DEPTH-entry return-address stack and RUN/HALT control; 1-cycle latency.
// No backpressure: one command is accepted per cycle in RUN, and commands other than resume/clr_err are dropped in HALT.
module pc_stack_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] target,
    input  logic       call,
    input  logic       ret,
    input  logic       halt,
    input  logic       resume,
    input  logic       clr_err,
    output logic [7:0] pc_out,
    output logic [3:0] depth,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       err,
    output logic       halted
);

    localparam int         IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DMAX = 4'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state;
    logic [7:0]    pc;
    logic [3:0]    dcnt;
    logic          err_q;
    logic [7:0]    entry [DEPTH];

    logic [3:0]    dcnt_m1;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic [7:0]    pc_inc;

    assign dcnt_m1  = dcnt - 4'd1;
    assign push_idx = dcnt[IW-1:0];
    assign pop_idx  = dcnt_m1[IW-1:0];
    assign pc_inc   = pc + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= 8'h00;
            dcnt  <= 4'd0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= 8'h00;
            end
        end else begin
            // A new overflow/underflow below overrides this clear.
            if (clr_err) begin
                err_q <= 1'b0;
            end
            if (state == RUN) begin
                if (halt) begin
                    state <= HALT;
                end else if (ret) begin
                    if (dcnt == 4'd0) begin
                        err_q <= 1'b1;
                    end else begin
                        pc   <= entry[pop_idx];
                        dcnt <= dcnt_m1;
                    end
                end else if (call) begin
                    if (dcnt == DMAX) begin
                        err_q <= 1'b1;
                    end else begin
                        entry[push_idx] <= pc_inc;
                        dcnt            <= dcnt + 4'd1;
                        pc              <= target;
                    end
                end else if (load) begin
                    pc <= target;
                end else if (inc) begin
                    pc <= pc_inc;
                end
            end else if (resume) begin
                state <= RUN;
            end
        end
    end

    assign pc_out      = pc;
    assign depth       = dcnt;
    assign stack_full  = (dcnt == DMAX);
    assign stack_empty = (dcnt == 4'd0);
    assign err         = err_q;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed bench for pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       inc, load, call, ret, halt, resume, clr_err;
    logic [7:0] target;
    logic [7:0] pc_out;
    logic [3:0] depth;
    logic       stack_full, stack_empty, err, halted;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_pc;
    bit         m_err;
    bit         m_halt;
    logic [7:0] m_stk [$];

    pc_stack_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .inc(inc), .load(load), .target(target),
        .call(call), .ret(ret), .halt(halt), .resume(resume), .clr_err(clr_err),
        .pc_out(pc_out), .depth(depth), .stack_full(stack_full),
        .stack_empty(stack_empty), .err(err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     32'(pc_out),      m_pc);
        chk({tag, ".depth"},  32'(depth),       m_stk.size());
        chk({tag, ".full"},   32'(stack_full),  int'(m_stk.size() == DEPTH));
        chk({tag, ".empty"},  32'(stack_empty), int'(m_stk.size() == 0));
        chk({tag, ".err"},    32'(err),         int'(m_err));
        chk({tag, ".halted"}, 32'(halted),      int'(m_halt));
    endtask

    function automatic void model_reset();
        m_pc   = 0;
        m_err  = 1'b0;
        m_halt = 1'b0;
        m_stk.delete();
    endfunction

    function automatic void model_step();
        bit fault = 1'b0;
        if (m_halt) begin
            if (resume) m_halt = 1'b0;
        end else if (halt) begin
            m_halt = 1'b1;
        end else if (ret) begin
            if (m_stk.size() == 0) fault = 1'b1;
            else m_pc = int'(m_stk.pop_back());
        end else if (call) begin
            if (m_stk.size() == DEPTH) fault = 1'b1;
            else begin
                m_stk.push_back(8'((m_pc + 1) % 256));
                m_pc = int'(target);
            end
        end else if (load) begin
            m_pc = int'(target);
        end else if (inc) begin
            m_pc = (m_pc + 1) % 256;
        end
        if (fault) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
    endfunction

    task automatic idle_inputs();
        inc = 0; load = 0; call = 0; ret = 0; halt = 0; resume = 0; clr_err = 0;
        target = 8'h00;
    endtask

    // Called shortly after a rising edge; applies and releases reset between edges.
    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #3;
        check_all(tag);
        #3;
        reset = 1'b0;
    endtask

    task automatic issue(input string tag, input bit i_inc, input bit i_load, input bit i_call,
                         input bit i_ret, input bit i_halt, input bit i_resume, input bit i_clr,
                         input logic [7:0] t);
        inc = i_inc; load = i_load; call = i_call; ret = i_ret;
        halt = i_halt; resume = i_resume; clr_err = i_clr; target = t;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        do_reset("rst0");

        // Increment and wrap
        issue("inc1", 1,0,0,0,0,0,0, 8'h00); chk("d_inc1", 32'(pc_out), 32'h01);
        issue("inc2", 1,0,0,0,0,0,0, 8'h00); chk("d_inc2", 32'(pc_out), 32'h02);
        issue("inc3", 1,0,0,0,0,0,0, 8'h00); chk("d_inc3", 32'(pc_out), 32'h03);
        issue("ldfe", 0,1,0,0,0,0,0, 8'hFE); chk("d_ldfe", 32'(pc_out), 32'hFE);
        issue("incf", 1,0,0,0,0,0,0, 8'h00); chk("d_incff", 32'(pc_out), 32'hFF);
        issue("wrap", 1,0,0,0,0,0,0, 8'h00); chk("d_wrap", 32'(pc_out), 32'h00);
        chk("d_wrap_err", 32'(err), 0);

        // Nested call/return
        issue("ld10", 0,1,0,0,0,0,0, 8'h10);
        issue("c40",  0,0,1,0,0,0,0, 8'h40); chk("d_c40", 32'(pc_out), 32'h40);
        issue("c80",  0,0,1,0,0,0,0, 8'h80); chk("d_c80_d", 32'(depth), 2);
        issue("r1",   0,0,0,1,0,0,0, 8'h00); chk("d_r1", 32'(pc_out), 32'h41);
        issue("r2",   0,0,0,1,0,0,0, 8'h00); chk("d_r2", 32'(pc_out), 32'h11);
        chk("d_r2_empty", 32'(stack_empty), 1);

        // Overflow, then clear
        for (int i = 0; i < DEPTH; i++) issue("fill", 0,0,1,0,0,0,0, 8'(8'h20 + i));
        issue("ovf", 0,0,1,0,0,0,0, 8'h99);
        chk("d_ovf_pc", 32'(pc_out), 32'h23);
        chk("d_ovf_full", 32'(stack_full), 1);
        chk("d_ovf_err", 32'(err), 1);
        issue("clr", 0,0,0,0,0,0,1, 8'h00); chk("d_clr", 32'(err), 0);

        // Underflow; set wins over clear
        do_reset("rst1");
        issue("unf",  0,0,0,1,0,0,0, 8'h00); chk("d_unf", 32'(err), 1);
        issue("unf2", 0,0,0,1,0,0,1, 8'h00); chk("d_unf2", 32'(err), 1);

        // Halt freezes the PC
        issue("ld20", 0,1,0,0,0,0,1, 8'h20);
        issue("hlt",  1,0,0,0,1,0,0, 8'h00); chk("d_hlt_pc", 32'(pc_out), 32'h20);
        for (int i = 0; i < 3; i++) issue("hold", 1,1,1,0,0,0,0, 8'h77);
        chk("d_hold_pc", 32'(pc_out), 32'h20);
        issue("res",  0,0,0,0,0,1,0, 8'h00); chk("d_res", 32'(halted), 0);
        issue("inc21",1,0,0,0,0,0,0, 8'h00); chk("d_inc21", 32'(pc_out), 32'h21);

        // Asynchronous reset with a part-filled stack
        issue("ld54", 0,1,0,0,0,0,0, 8'h54);
        for (int i = 0; i < 3; i++) issue("c3", 0,0,1,0,0,0,0, 8'h54);
        issue("inc55",1,0,0,0,0,0,0, 8'h00);
        chk("d_pre_d", 32'(depth), 3);
        do_reset("arst");
        issue("rpost",0,0,0,1,0,0,0, 8'h00); chk("d_rpost", 32'(err), 1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rrst");
            end else begin
                issue("rnd",
                      $urandom_range(99) < 40, $urandom_range(99) < 20,
                      $urandom_range(99) < 25, $urandom_range(99) < 25,
                      $urandom_range(99) < 6,  $urandom_range(99) < 30,
                      $urandom_range(99) < 10, 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
